// File: rtl/axi_to_mem_pkg.sv
// Shared definitions for the AXI-to-SRAM bridge: FSM encodings, burst types, response codes.
`default_nettype none

package axi_to_mem_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE        = 3'd0;
  localparam state_t ST_READ        = 3'd1;
  localparam state_t ST_WAIT_WVALID = 3'd2;
  localparam state_t ST_WRITE       = 3'd3;
  localparam state_t ST_SEND_B      = 3'd4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

`default_nettype wire

// File: rtl/axi_bus.sv
// AXI_BUS: AXI4 channel bundle (AW/W/B/AR/R) with Slave and Master modports.
`default_nettype none

interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 10
);

  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

endinterface

`default_nettype wire

// File: rtl/axi_to_mem_addr_gen.sv
// axi_to_mem_addr_gen: next-beat address for FIXED/INCR/WRAP bursts.
// WRAP addressing is built only with AXI_TO_MEM_WRAP_BURST_EN; otherwise WRAP behaves as INCR.
`default_nettype none

module axi_to_mem_addr_gen
  import axi_to_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  logic [ADDR_WIDTH-1:0] beat_bytes;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] incr_addr;

  assign beat_bytes = ADDR_WIDTH'(1) << size_i;
  assign aligned    = addr_i & ~(beat_bytes - ADDR_WIDTH'(1));
  assign incr_addr  = aligned + beat_bytes;

`ifdef AXI_TO_MEM_WRAP_BURST_EN
  logic [ADDR_WIDTH-1:0] wrap_mask;

  // Wrap window is (len+1) beats, aligned to its own size.
  assign wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);

  always_comb begin
    next_addr_o = incr_addr;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr_o = incr_addr;
    endcase
  end
`else
  logic unused_len;
  assign unused_len = ^len_i;

  always_comb begin
    next_addr_o = incr_addr;
    if (burst_i == BURST_FIXED) begin
      next_addr_o = addr_i;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/axi_to_mem.sv
// axi_to_mem: AXI4 slave to single-beat SRAM bridge, one burst at a time, 1-cycle read latency memory.
// Optional macro AXI_TO_MEM_WRAP_BURST_EN enables WRAP burst addressing.
`default_nettype none

module axi_to_mem
  import axi_to_mem_pkg::*;
#(
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  AXI_BUS.Slave                       slave,
  output logic                        req_o,
  output logic                        we_o,
  output logic [AXI_ADDR_WIDTH-1:0]   addr_o,
  output logic [AXI_DATA_WIDTH/8-1:0] be_o,
  output logic [AXI_DATA_WIDTH-1:0]   data_o,
  input  logic [AXI_DATA_WIDTH-1:0]   data_i,
  input  logic [AXI_USER_WIDTH-1:0]   user_i,
  output logic [AXI_USER_WIDTH-1:0]   user_o
);

  state_t                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]                len_q, len_d;
  logic [2:0]                size_q, size_d;
  logic [1:0]                burst_q, burst_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_USER_WIDTH-1:0] user_q, user_d;
  logic [AXI_ADDR_WIDTH-1:0] next_addr;
  logic                      last_beat;

  axi_to_mem_addr_gen #(
    .ADDR_WIDTH (AXI_ADDR_WIDTH)
  ) u_addr_gen (
    .addr_i      (addr_q),
    .len_i       (len_q),
    .size_i      (size_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    addr_d  = addr_q;
    user_d  = user_q;

    req_o  = 1'b0;
    we_o   = 1'b0;
    addr_o = addr_q;
    be_o   = '0;
    data_o = '0;
    user_o = '0;

    slave.aw_ready = 1'b0;
    slave.w_ready  = 1'b0;
    slave.ar_ready = 1'b0;
    slave.b_valid  = 1'b0;
    slave.b_id     = id_q;
    slave.b_resp   = RESP_OKAY;
    slave.b_user   = user_q;
    slave.r_valid  = 1'b0;
    slave.r_id     = id_q;
    slave.r_data   = data_i;
    slave.r_resp   = RESP_OKAY;
    slave.r_last   = last_beat;
    slave.r_user   = user_i;

    case (state_q)
      ST_IDLE: begin
        if (slave.ar_valid) begin
          slave.ar_ready = 1'b1;
          id_d    = slave.ar_id;
          addr_d  = slave.ar_addr;
          len_d   = slave.ar_len;
          size_d  = slave.ar_size;
          burst_d = slave.ar_burst;
          cnt_d   = '0;
          req_o   = 1'b1;
          addr_o  = slave.ar_addr;
          state_d = ST_READ;
        end else if (slave.aw_valid) begin
          slave.aw_ready = 1'b1;
          id_d    = slave.aw_id;
          addr_d  = slave.aw_addr;
          len_d   = slave.aw_len;
          size_d  = slave.aw_size;
          burst_d = slave.aw_burst;
          user_d  = slave.aw_user;
          cnt_d   = '0;
          state_d = ST_WAIT_WVALID;
        end
      end

      ST_READ: begin
        slave.r_valid = 1'b1;
        if (slave.r_ready) begin
          if (last_beat) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = next_addr;
            req_o  = 1'b1;
            addr_o = next_addr;
          end
        end else begin
          // Stalled: keep re-reading the same beat so data_i stays valid next cycle.
          req_o  = 1'b1;
          addr_o = addr_q;
        end
      end

      ST_WAIT_WVALID, ST_WRITE: begin
        slave.w_ready = 1'b1;
        if (slave.w_valid) begin
          req_o   = 1'b1;
          we_o    = 1'b1;
          addr_o  = addr_q;
          be_o    = slave.w_strb;
          data_o  = slave.w_data;
          user_o  = user_q;
          addr_d  = next_addr;
          cnt_d   = cnt_q + 8'd1;
          state_d = (slave.w_last || last_beat) ? ST_SEND_B : ST_WRITE;
        end
      end

      ST_SEND_B: begin
        slave.b_valid = 1'b1;
        if (slave.b_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      user_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      user_q  <= user_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_to_mem.sv
// tb_axi_to_mem: directed AXI bursts against a 1-cycle SRAM model, scoreboard-checked.
`default_nettype none

module tb_axi_to_mem;
  import axi_to_mem_pkg::*;

  localparam int IDW = 10;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int UW  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IDW), .AXI_USER_WIDTH(UW)) axi ();

  logic          req, we;
  logic [63:0]   addr, wdata, rdata;
  logic [7:0]    be;
  logic [UW-1:0] user_in, user_out;

  axi_to_mem #(
    .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .slave(axi),
    .req_o(req), .we_o(we), .addr_o(addr), .be_o(be), .data_o(wdata),
    .data_i(rdata), .user_i(user_in), .user_o(user_out)
  );

  // SRAM model: 1-cycle read latency, byte-enable writes, read user = word index bits.
  logic [63:0] mem [logic [63:0]];
  initial begin rdata = '0; user_in = '0; end
  always @(posedge clk) begin
    if (req) begin
      if (we) begin
        logic [63:0] w;
        w = mem.exists(addr >> 3) ? mem[addr >> 3] : 64'h0;
        for (int i = 0; i < 8; i++) if (be[i]) w[i*8 +: 8] = wdata[i*8 +: 8];
        mem[addr >> 3] = w;
      end else begin
        rdata   <= mem.exists(addr >> 3) ? mem[addr >> 3] : 64'h0;
        user_in <= addr[12:3];
      end
    end
  end

  typedef struct { logic [63:0] a; logic [7:0] be; logic [63:0] d; logic [UW-1:0] u; } req_t;
  typedef struct { logic [63:0] d; logic last; logic [IDW-1:0] id; logic [UW-1:0] u; } r_t;
  typedef struct { logic [IDW-1:0] id; logic [UW-1:0] u; } b_t;
  req_t exp_req[$];
  r_t   exp_r[$];
  b_t   exp_b[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic [63:0] a, input logic [7:0] b, input logic [63:0] d, input logic [UW-1:0] u);
    req_t e; e.a = a; e.be = b; e.d = d; e.u = u; exp_req.push_back(e);
  endtask
  task automatic push_r(input logic [63:0] d, input logic last, input logic [IDW-1:0] id, input logic [UW-1:0] u);
    r_t e; e.d = d; e.last = last; e.id = id; e.u = u; exp_r.push_back(e);
  endtask
  task automatic push_b(input logic [IDW-1:0] id, input logic [UW-1:0] u);
    b_t e; e.id = id; e.u = u; exp_b.push_back(e);
  endtask

  // Monitor: pops expectations whenever the DUT presents an output event.
  logic        r_stall_prev = 1'b0, b_stall_prev = 1'b0;
  logic [63:0] r_data_prev;
  logic        r_last_prev;
  always @(negedge clk) begin
    if (rst_n) begin
      if (req && we) begin
        if (exp_req.size() == 0) check("unexpected_write_req", 1, 0);
        else begin
          req_t e; e = exp_req.pop_front();
          check("wr_addr", addr, e.a);
          check("wr_be", be, e.be);
          check("wr_data", wdata, e.d);
          check("wr_user", user_out, e.u);
        end
      end
      if (r_stall_prev) begin
        check("r_hold_valid", axi.r_valid, 1);
        check("r_hold_data", axi.r_data, r_data_prev);
        check("r_hold_last", axi.r_last, r_last_prev);
      end
      if (b_stall_prev) check("b_hold_valid", axi.b_valid, 1);
      if (axi.r_valid && axi.r_ready) begin
        if (exp_r.size() == 0) check("unexpected_r_beat", 1, 0);
        else begin
          r_t e; e = exp_r.pop_front();
          check("r_data", axi.r_data, e.d);
          check("r_last", axi.r_last, e.last);
          check("r_id", axi.r_id, e.id);
          check("r_user", axi.r_user, e.u);
          check("r_resp", axi.r_resp, RESP_OKAY);
        end
      end
      if (axi.b_valid && axi.b_ready) begin
        if (exp_b.size() == 0) check("unexpected_b", 1, 0);
        else begin
          b_t e; e = exp_b.pop_front();
          check("b_id", axi.b_id, e.id);
          check("b_user", axi.b_user, e.u);
          check("b_resp", axi.b_resp, RESP_OKAY);
        end
      end
      if (axi.ar_valid && axi.aw_valid) check("prio_aw_ready_low", axi.aw_ready, 0);
      r_stall_prev = axi.r_valid && !axi.r_ready;
      r_data_prev  = axi.r_data;
      r_last_prev  = axi.r_last;
      b_stall_prev = axi.b_valid && !axi.b_ready;
    end
  end

  task automatic aw_send(input logic [IDW-1:0] id, input logic [63:0] a, input logic [7:0] len,
                         input logic [1:0] burst, input logic [UW-1:0] u);
    int n = 0;
    axi.aw_id = id; axi.aw_addr = a; axi.aw_len = len; axi.aw_size = 3'd3;
    axi.aw_burst = burst; axi.aw_user = u; axi.aw_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!axi.aw_ready && n < 200);
    if (!axi.aw_ready) check("aw_handshake_timeout", 0, 1);
    @(posedge clk); #1 axi.aw_valid = 1'b0;
  endtask

  task automatic ar_send(input logic [IDW-1:0] id, input logic [63:0] a, input logic [7:0] len,
                         input logic [1:0] burst);
    int n = 0;
    axi.ar_id = id; axi.ar_addr = a; axi.ar_len = len; axi.ar_size = 3'd3;
    axi.ar_burst = burst; axi.ar_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!axi.ar_ready && n < 200);
    if (!axi.ar_ready) check("ar_handshake_timeout", 0, 1);
    @(posedge clk); #1 axi.ar_valid = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] strb, input logic last);
    int n = 0;
    axi.w_data = d; axi.w_strb = strb; axi.w_last = last; axi.w_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!axi.w_ready && n < 200);
    if (!axi.w_ready) check("w_handshake_timeout", 0, 1);
    @(posedge clk); #1 axi.w_valid = 1'b0; axi.w_last = 1'b0;
  endtask

  task automatic write_txn(input logic [IDW-1:0] id, input logic [63:0] a, input logic [7:0] len,
                           input logic [1:0] burst, input logic [UW-1:0] u,
                           input logic [63:0] d0, d1, d2, d3, input logic [7:0] strb);
    logic [63:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    aw_send(id, a, len, burst, u);
    for (int i = 0; i <= int'(len); i++) w_send(d[i], strb, i == int'(len));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_req.size() + exp_r.size() + exp_b.size()) != 0 && n < 500) begin
      @(negedge clk); n++;
    end
    if ((exp_req.size() + exp_r.size() + exp_b.size()) != 0) begin
      check("drain_timeout", 0, 1);
      exp_req.delete(); exp_r.delete(); exp_b.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    axi.aw_valid = 0; axi.aw_id = '0; axi.aw_addr = '0; axi.aw_len = '0; axi.aw_size = '0;
    axi.aw_burst = '0; axi.aw_user = '0;
    axi.w_valid = 0; axi.w_data = '0; axi.w_strb = '0; axi.w_last = 0;
    axi.ar_valid = 0; axi.ar_id = '0; axi.ar_addr = '0; axi.ar_len = '0; axi.ar_size = '0;
    axi.ar_burst = '0;
    axi.r_ready = 1; axi.b_ready = 1;

    repeat (2) @(negedge clk);
    check("rst_ar_ready", axi.ar_ready, 0);
    check("rst_aw_ready", axi.aw_ready, 0);
    check("rst_w_ready", axi.w_ready, 0);
    check("rst_r_valid", axi.r_valid, 0);
    check("rst_b_valid", axi.b_valid, 0);
    check("rst_req", req, 0);
    check("rst_we", we, 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (2) @(posedge clk); #1;

    // Single write then read back
    push_req(64'h8000_0000, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 10'h2A5);
    push_b(10'd5, 10'h2A5);
    write_txn(10'd5, 64'h8000_0000, 8'd0, BURST_INCR, 10'h2A5, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 0, 8'hFF);
    drain();
    push_r(64'hDEAD_BEEF_CAFE_F00D, 1, 10'd7, 10'h000);
    ar_send(10'd7, 64'h8000_0000, 8'd0, BURST_INCR);
    drain();

    // INCR burst of 4 and read back
    push_req(64'h100, 8'hFF, 64'h1111_1111_1111_1111, 10'h011);
    push_req(64'h108, 8'hFF, 64'h2222_2222_2222_2222, 10'h011);
    push_req(64'h110, 8'hFF, 64'h3333_3333_3333_3333, 10'h011);
    push_req(64'h118, 8'hFF, 64'h4444_4444_4444_4444, 10'h011);
    push_b(10'd3, 10'h011);
    write_txn(10'd3, 64'h100, 8'd3, BURST_INCR, 10'h011, 64'h1111_1111_1111_1111,
              64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 8'hFF);
    drain();
    push_r(64'h1111_1111_1111_1111, 0, 10'd4, 10'h020);
    push_r(64'h2222_2222_2222_2222, 0, 10'd4, 10'h021);
    push_r(64'h3333_3333_3333_3333, 0, 10'd4, 10'h022);
    push_r(64'h4444_4444_4444_4444, 1, 10'd4, 10'h023);
    ar_send(10'd4, 64'h100, 8'd3, BURST_INCR);
    drain();

    // Partial strobe: upper bytes retain old value
    push_req(64'h100, 8'h0F, 64'hAAAA_AAAA_5555_5555, 10'h3FF);
    push_b(10'd1, 10'h3FF);
    write_txn(10'd1, 64'h100, 8'd0, BURST_INCR, 10'h3FF, 64'hAAAA_AAAA_5555_5555, 0, 0, 0, 8'h0F);
    drain();
    push_r(64'h1111_1111_5555_5555, 1, 10'd2, 10'h020);
    ar_send(10'd2, 64'h100, 8'd0, BURST_INCR);
    drain();

    // Read backpressure: r_ready low 3 cycles
    axi.r_ready = 0;
    push_r(64'h2222_2222_2222_2222, 0, 10'd9, 10'h021);
    push_r(64'h3333_3333_3333_3333, 1, 10'd9, 10'h022);
    ar_send(10'd9, 64'h108, 8'd1, BURST_INCR);
    repeat (3) @(posedge clk);
    #1 axi.r_ready = 1;
    drain();

    // B backpressure: b_ready low 2 cycles
    axi.b_ready = 0;
    push_req(64'h200, 8'hFF, 64'h0F0F_0F0F_0F0F_0F0F, 10'h055);
    push_b(10'd6, 10'h055);
    write_txn(10'd6, 64'h200, 8'd0, BURST_INCR, 10'h055, 64'h0F0F_0F0F_0F0F_0F0F, 0, 0, 0, 8'hFF);
    repeat (2) @(posedge clk);
    #1 axi.b_ready = 1;
    drain();

    // AR and AW together: read served first, AW only after read completes
    push_r(64'h3333_3333_3333_3333, 1, 10'h03A, 10'h022);
    push_req(64'h300, 8'hFF, 64'h0123_4567_89AB_CDEF, 10'h100);
    push_b(10'h01C, 10'h100);
    fork
      ar_send(10'h03A, 64'h110, 8'd0, BURST_INCR);
      begin
        aw_send(10'h01C, 64'h300, 8'd0, BURST_INCR, 10'h100);
        check("aw_after_read_done", exp_r.size(), 0);
        w_send(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
      end
    join
    drain();

    // WRAP burst len 3 at 0x118
`ifdef AXI_TO_MEM_WRAP_BURST_EN
    push_req(64'h118, 8'hFF, 64'hA0, 10'h0AA);
    push_req(64'h100, 8'hFF, 64'hA1, 10'h0AA);
    push_req(64'h108, 8'hFF, 64'hA2, 10'h0AA);
    push_req(64'h110, 8'hFF, 64'hA3, 10'h0AA);
`else
    push_req(64'h118, 8'hFF, 64'hA0, 10'h0AA);
    push_req(64'h120, 8'hFF, 64'hA1, 10'h0AA);
    push_req(64'h128, 8'hFF, 64'hA2, 10'h0AA);
    push_req(64'h130, 8'hFF, 64'hA3, 10'h0AA);
`endif
    push_b(10'd2, 10'h0AA);
    write_txn(10'd2, 64'h118, 8'd3, BURST_WRAP, 10'h0AA, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 8'hFF);
    drain();
`ifdef AXI_TO_MEM_WRAP_BURST_EN
    push_r(64'hA0, 0, 10'd8, 10'h023);
    push_r(64'hA1, 0, 10'd8, 10'h020);
    push_r(64'hA2, 0, 10'd8, 10'h021);
    push_r(64'hA3, 1, 10'd8, 10'h022);
`else
    push_r(64'hA0, 0, 10'd8, 10'h023);
    push_r(64'hA1, 0, 10'd8, 10'h024);
    push_r(64'hA2, 0, 10'd8, 10'h025);
    push_r(64'hA3, 1, 10'd8, 10'h026);
`endif
    ar_send(10'd8, 64'h118, 8'd3, BURST_WRAP);
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/axi_to_mem.md
Name: axi_to_mem

Overview:
- AXI4 slave-to-SRAM bridge: converts read and write bursts on one AXI_BUS slave port into single-beat memory requests.
- Sits behind the SoC AXI crossbar's DRAM master port and drives a 64-bit test RAM.
- Target memory has fixed 1-cycle read latency and always grants.
- One transaction (read or write burst) at a time.

Parameters:
- AXI_ID_WIDTH, 10, ID width of slave port (SoC uses 5).
- AXI_ADDR_WIDTH, 64, address width.
- AXI_DATA_WIDTH, 64, data width; strobe width = AXI_DATA_WIDTH/8.
- AXI_USER_WIDTH, 10, user sideband width (SoC uses 64).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- slave  AXI_BUS.Slave modport  params above  AXI4 slave (AW/W/B/AR/R channels).
- req_o  out  1  memory request.
- we_o  out  1  1 = write, 0 = read.
- addr_o  out  AXI_ADDR_WIDTH  byte address of beat.
- be_o  out  AXI_DATA_WIDTH/8  byte enables (write strobes).
- data_o  out  AXI_DATA_WIDTH  write data.
- data_i  in  AXI_DATA_WIDTH  read data, valid the cycle after req_o with we_o = 0.
- user_i  in  AXI_USER_WIDTH  read user sideband, returned as r_user.
- user_o  out  AXI_USER_WIDTH  write user sideband; carries aw_user during write beats.

Behaviour:
- Reset (async, rst_ni low):
  - FSM = IDLE.
  - All ready/valid outputs 0.
  - req_o = 0, we_o = 0.
  - Beat counter, stored ID, len, size, burst and address cleared to 0.
- FSM states: IDLE, READ, WAIT_WVALID, WRITE, SEND_B.
- IDLE:
  - ar_valid has priority over aw_valid when both are asserted.
  - On ar_valid: ar_ready = 1 for one cycle; latch id, addr, len, size, burst; issue req_o = 1, we_o = 0, addr_o = ar_addr; go to READ.
  - Else on aw_valid: aw_ready = 1; latch id, addr, len, size, burst, user; go to WAIT_WVALID.
- READ:
  - r_valid = 1 one cycle after each request; r_data = data_i; r_resp = OKAY; r_id = latched ID; r_user = user_i; r_last = 1 when beat count == len.
  - On r_valid && r_ready, not last: increment count, compute next address, issue next req_o in the same cycle.
  - On r_valid && r_ready, last: return to IDLE with no new request.
  - If r_ready = 0: re-issue req_o at the current address each cycle so data_i stays valid; r_valid held high; r_data/r_last stable.
- WAIT_WVALID / WRITE:
  - w_ready = 1 whenever in these states.
  - Each w_valid beat: req_o = 1, we_o = 1, addr_o = current address, be_o = w_strb, data_o = w_data, same cycle (zero latency).
  - Advance address and count per beat.
  - On w_last (or count == len): go to SEND_B.
  - With w_valid low: no request issued.
- SEND_B:
  - b_valid = 1, b_resp = OKAY, b_id = latched AW ID, b_user = latched aw_user.
  - Hold until b_ready, then go to IDLE.
- Address generation (beat size = 1 << size bytes):
  - FIXED: address constant.
  - INCR: next = aligned(addr) + beat size.
  - WRAP: next wraps within (len+1) × beat-size boundary, aligned to that boundary.
- Arithmetic: address math at full AXI_ADDR_WIDTH; len 8-bit, up to 256 beats; no 4 KiB boundary checking.
- Simultaneous events: a new AR/AW is never accepted outside IDLE (ar_ready = aw_ready = 0); accepting does not occur in the same cycle a previous transaction completes (one-cycle IDLE gap).
- Reset mid-burst: aborts immediately; outstanding beats dropped.

Optional Feature:
- Macro: AXI_TO_MEM_WRAP_BURST_EN.
- Defined: WRAP bursts use wrap addressing as above.
- Undefined: WRAP is treated exactly as INCR; FIXED and INCR are unchanged.

Decomposition:
- Shared package axi_to_mem_pkg holds:
  - State enum (IDLE, READ, WAIT_WVALID, WRITE, SEND_B).
  - Burst encodings FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10.
  - RESP_OKAY = 2'b00.
- One sub-module, axi_to_mem_addr_gen: combinational next-beat address from (addr, len, size, burst).

Test Plan:
- Single write, then read back: AW addr 0x8000_0000, len 0, size 3; W data 0xDEAD_BEEF_CAFE_F00D, strb 0xFF -> one req_o/we_o pulse at 0x8000_0000; B OKAY with matching ID. AR same addr -> r_data 0xDEAD_BEEF_CAFE_F00D, r_last = 1.
- INCR write, len 3, size 3, at 0x100 -> requests at 0x100, 0x108, 0x110, 0x118. Read back: 4 beats in order, r_last only on beat 4.
- Partial strobe: write strb 0x0F -> be_o = 0x0F; read-back upper 4 bytes keep their old value.
- Backpressure: read burst len 1 with r_ready low for 3 cycles -> r_valid stays high, r_data stable, no beat skipped. b_ready low 2 cycles -> b_valid held.
- Priority: AR and AW asserted together in IDLE -> AR accepted first; AW accepted after the read completes.
- WRAP (macro on): len 3, size 3, addr 0x118 -> addresses 0x118, 0x100, 0x108, 0x110. Macro off -> 0x118, 0x120, 0x128, 0x130.
